// File: rtl/seven_seg_scan_if.sv
// Signal bundle between the IO register block (master) and the
// seven-segment scan driver (slave).
interface seven_seg_scan_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic                  load;
  logic                  blank_lz;
  logic                  en;
  logic [7:0]            SEG;
  logic [N_DIGITS-1:0]   AN;
  logic                  frame_done;

  modport master (
    output value, dp, load, blank_lz, en,
    input  SEG, AN, frame_done
  );

  modport slave (
    input  value, dp, load, blank_lz, en,
    output SEG, AN, frame_done
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero
// blanking and frame-boundary (tear-free) commit of new display data.
module seven_seg_scan #(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 100000,
  parameter bit HEX_EN   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scan_if.slave  bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_pend_val;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend_flag;
  logic [4*N_DIGITS-1:0] r_disp_val;
  logic [N_DIGITS-1:0]   r_disp_dp;
  logic [7:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_code;
  logic                  w_dp;
  logic                  w_suppress;

  function automatic logic [6:0] f_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001101;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!HEX_EN && (code > 4'd9)) g = 7'b1111111;
    return g;
  endfunction

  assign w_tick = (r_presc == PRESC_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

  always_comb begin
    logic l_zero_above;
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_code       = 4'd0;
    w_dp         = 1'b0;
    w_suppress   = 1'b0;
    l_zero_above = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_code = r_disp_val[4*i +: 4];
        w_dp   = r_disp_dp[i];
      end
    end
    // Walk from the most significant digit down; digit 0 is never blanked.
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      l_zero_above = l_zero_above && (r_disp_val[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) w_suppress = bus.blank_lz && l_zero_above;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_seg        <= 8'hFF;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_done <= w_wrap;
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + 1'b1;

      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp;
      end

      // Display data only changes as the scan returns to digit 0.
      if (w_wrap) begin
        r_pend_flag <= 1'b0;
        if (bus.load) begin
          r_disp_val <= bus.value;
          r_disp_dp  <= bus.dp;
        end else if (r_pend_flag) begin
          r_disp_val <= r_pend_val;
          r_disp_dp  <= r_pend_dp;
        end
      end else if (bus.load) begin
        r_pend_flag <= 1'b1;
      end

      if (bus.en) begin
        r_seg <= {(w_suppress ? 7'b1111111 : f_glyph(w_code)), ~w_dp};
        r_an  <= ~(N_DIGITS'(1) << r_idx);
      end else begin
        r_seg <= 8'hFF;
        r_an  <= '1;
      end
    end
  end

  assign bus.SEG        = r_seg;
  assign bus.AN         = r_an;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 4 digits, DIV=4, hex and non-hex
// instances driven by the same stimulus.
module tb_seven_seg_scan;
  localparam int N = 4;
  localparam int D = 4;

  typedef struct {
    string           name;
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] seg_h;
    logic [3:0][7:0] seg_n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blz = 1'b0;
  logic        en = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_scan_if #(.N_DIGITS(N)) bus_h ();
  seven_seg_scan_if #(.N_DIGITS(N)) bus_n ();

  assign bus_h.value    = value;
  assign bus_h.dp       = dp;
  assign bus_h.load     = load;
  assign bus_h.blank_lz = blz;
  assign bus_h.en       = en;
  assign bus_n.value    = value;
  assign bus_n.dp       = dp;
  assign bus_n.load     = load;
  assign bus_n.blank_lz = blz;
  assign bus_n.en       = en;

  seven_seg_scan #(.N_DIGITS(N), .DIV(D), .HEX_EN(1'b1)) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (bus_h)
  );

  seven_seg_scan #(.N_DIGITS(N), .DIV(D), .HEX_EN(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_frame(input string name, input int budget, output int n);
    n = 0;
    while ((bus_h.frame_done !== 1'b1) && (n < budget)) begin
      step();
      n++;
    end
    check($sformatf("%s frame_done seen", name), {31'd0, bus_h.frame_done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [3:0][7:0] exp_h,
                             input logic [3:0][7:0] exp_n);
    for (int j = 0; j < 16; j++) begin
      int         d;
      logic [3:0] an_exp;
      step();
      d      = j / 4;
      an_exp = ~(4'b0001 << d);
      check($sformatf("%s seg_h c%0d", tag, j), bus_h.SEG, exp_h[d]);
      check($sformatf("%s seg_n c%0d", tag, j), bus_n.SEG, exp_n[d]);
      check($sformatf("%s an_h c%0d", tag, j), bus_h.AN, an_exp);
      check($sformatf("%s an_n c%0d", tag, j), bus_n.AN, an_exp);
      check($sformatf("%s fd_h c%0d", tag, j), bus_h.frame_done, (j == 15) ? 1 : 0);
      check($sformatf("%s fd_n c%0d", tag, j), bus_n.frame_done, (j == 15) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   n;

    vecs[0] = '{"scan1234", 16'h1234, 4'b0100, 1'b0,
                {8'b10011111, 8'b00100100, 8'b00001101, 8'b10011001},
                {8'b10011111, 8'b00100100, 8'b00001101, 8'b10011001}};
    vecs[1] = '{"hexABCD", 16'hABCD, 4'b0000, 1'b0,
                {8'b00010001, 8'b11000001, 8'b01100011, 8'b10000101},
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[2] = '{"lz0050", 16'h0050, 4'b0000, 1'b1,
                {8'hFF, 8'hFF, 8'b01001001, 8'b00000011},
                {8'hFF, 8'hFF, 8'b01001001, 8'b00000011}};
    vecs[3] = '{"lz0000", 16'h0000, 4'b0000, 1'b1,
                {8'hFF, 8'hFF, 8'hFF, 8'b00000011},
                {8'hFF, 8'hFF, 8'hFF, 8'b00000011}};
    vecs[4] = '{"lz0500dp3", 16'h0500, 4'b1000, 1'b1,
                {8'b11111110, 8'b01001001, 8'b00000011, 8'b00000011},
                {8'b11111110, 8'b01001001, 8'b00000011, 8'b00000011}};
    vecs[5] = '{"nolz0050", 16'h0050, 4'b0000, 1'b0,
                {8'b00000011, 8'b00000011, 8'b01001001, 8'b00000011},
                {8'b00000011, 8'b00000011, 8'b01001001, 8'b00000011}};

    // Reset held for three edges, then the first scanned output.
    steps(3);
    check("reset SEG", bus_h.SEG, 8'hFF);
    check("reset AN", bus_h.AN, 4'b1111);
    check("reset frame_done", bus_h.frame_done, 0);
    rst = 1'b0;
    step();
    check("post-reset AN", bus_h.AN, 4'b1110);
    check("post-reset SEG", bus_h.SEG, 8'b00000011);

    for (int v = 0; v < 6; v++) begin
      value = vecs[v].value;
      dp    = vecs[v].dp;
      blz   = vecs[v].blz;
      load  = 1'b1;
      step();
      load  = 1'b0;
      wait_frame(vecs[v].name, 40, n);
      check_frame(vecs[v].name, vecs[v].seg_h, vecs[v].seg_n);
    end

    // Load during digit 2: the current frame keeps the old value.
    blz   = 1'b0;
    value = 16'h2222;
    dp    = 4'b0000;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame("tear setup", 40, n);
    steps(8);
    value = 16'h1111;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("tear d2 SEG", bus_h.SEG, 8'b00100101);
    check("tear d2 AN", bus_h.AN, 4'b1011);
    steps(4);
    check("tear d3 SEG", bus_h.SEG, 8'b00100101);
    check("tear d3 AN", bus_h.AN, 4'b0111);
    steps(3);
    check("tear wrap fd", bus_h.frame_done, 1);
    step();
    check("tear next d0 SEG", bus_h.SEG, 8'b10011111);
    check("tear next d0 AN", bus_h.AN, 4'b1110);

    // Load on the wrap edge commits straight into the next frame.
    steps(14);
    value = 16'h5678;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("wrapload fd", bus_h.frame_done, 1);
    step();
    check("wrapload d0 SEG", bus_h.SEG, 8'b00000001);
    check("wrapload d0 AN", bus_h.AN, 4'b1110);
    steps(4);
    check("wrapload d1 SEG", bus_h.SEG, 8'b00011011);

    // Display disabled at index 1; scanning, loading and frame_done carry on.
    wait_frame("en setup", 40, n);
    steps(4);
    en = 1'b0;
    step();
    check("en0 SEG", bus_h.SEG, 8'hFF);
    check("en0 AN", bus_h.AN, 4'b1111);
    value = 16'h0009;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("en0 SEG hold", bus_h.SEG, 8'hFF);
    steps(9);
    check("en0 fd early", bus_h.frame_done, 0);
    step();
    check("en0 fd on time", bus_h.frame_done, 1);
    en = 1'b1;
    step();
    check("en1 AN", bus_h.AN, 4'b1110);
    check("en1 SEG", bus_h.SEG, 8'b00001001);

    // Reset at index 2 with a load still pending.
    steps(7);
    value = 16'h7777;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("pre-rst d2 SEG", bus_h.SEG, 8'b00000011);
    rst = 1'b1;
    step();
    check("midrst SEG", bus_h.SEG, 8'hFF);
    check("midrst AN", bus_h.AN, 4'b1111);
    check("midrst fd", bus_h.frame_done, 0);
    rst = 1'b0;
    step();
    check("midrst release AN", bus_h.AN, 4'b1110);
    check("midrst release SEG", bus_h.SEG, 8'b00000011);
    wait_frame("midrst", 40, n);
    check("midrst frame length", n, 15);
    step();
    check("midrst pending dropped", bus_h.SEG, 8'b00000011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Takes a packed vector of 4-bit digit codes plus per-digit decimal points and scans one digit at a time.
- Features: optional hex glyphs, leading-zero suppression, global enable, and tear-free update at frame boundaries.
- Sits between the CPU debug/IO register and the board display pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (min 1).
- DIV, 100000, clocks each digit is held before advancing (min 1).
- HEX_EN, 1, 1 = codes 10..15 show A,b,C,d,E,F; 0 = codes 10..15 blank.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- value  in  4*N_DIGITS  digit codes; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp  in  N_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  one-cycle strobe; captures value/dp.
- blank_lz  in  1  1 = suppress leading zeros.
- en  in  1  0 = display dark, scanning continues.
- SEG  out  8  active-low segments; SEG[7:1] = a,b,c,d,e,f,g; SEG[0] = dp.
- AN  out  N_DIGITS  active-low digit select; AN[i] low selects digit i.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset (including mid-operation), next edge:
  - SEG = 8'hFF, AN = all ones, frame_done = 0.
  - Prescaler = 0, digit index = 0.
  - Pending and display registers = 0 (value and dp); pending flag = 0.
- Prescaler counts 0..DIV-1, width max(1, clog2(DIV)).
  - At DIV-1 it wraps to 0 and the index advances.
  - Index N_DIGITS-1 wraps to 0; frame_done = 1 on that same edge for one cycle.
  - DIV = 1 advances every cycle.
- Load and commit:
  - load = 1 captures value/dp into the pending register and sets the pending flag.
  - Commit occurs on the edge where the index wraps to 0: display register <= pending, flag cleared. With no pending flag, the display register holds.
  - load on the same cycle as the wrap: the incoming value/dp is committed directly and the flag stays clear.
  - A second load before commit overwrites the pending value (last load wins).
- Output timing: SEG/AN are registered from the index and display register, so they update one clock after the index changes.
- Decode, active low, glyph bits a..g (SEG[7:1]):
  - 0: 0000001; 1: 1001111; 2: 0010010; 3: 0000110; 4: 1001100
  - 5: 0100100; 6: 0100000; 7: 0001101; 8: 0000000; 9: 0000100
  - A: 0001000; b: 1100000; C: 0110001; d: 1000010; E: 0110000; F: 0111000 (HEX_EN = 1 only; else 1111111).
- SEG[0] = ~dp[idx].
- Leading-zero suppression: when blank_lz = 1, digit i > 0 has glyph bits forced to 1111111 if its code and all higher digits' codes are 0.
  - Digit 0 is never suppressed.
  - The dp bit is unaffected.
  - The digit's AN is still driven low.
- en = 0: SEG = 8'hFF and AN = all ones (registered, one-cycle latency). Prescaler, index, load/commit and frame_done continue unchanged.
- Exactly one AN bit is low at any time when en = 1 and not in reset.

Test Plan:
1. Reset: N_DIGITS=4, DIV=4; hold rst 3 cycles -> SEG=8'hFF, AN=4'b1111, frame_done=0. After release, the first output is AN=1110, SEG=8'b00000011 (display register = 0).
2. Scan/load: load value=16'h1234, dp=4'b0100, then wait for commit.
   - Sequence AN 1110/1101/1011/0111, each held 4 cycles.
   - SEG = 10011001, 00001101, 00100100 (dp lit), 10011111.
   - frame_done pulses every 16 cycles.
3. Hex mode: load 16'hABCD, dp=0, HEX_EN=1 -> digit0..3 SEG = 10000101, 01100011, 11000001, 00010001. Same stimulus with HEX_EN=0 -> all four SEG = 8'hFF with AN cycling.
4. Leading zeros: blank_lz=1.
   - value=16'h0050 -> digits 3,2 SEG=8'hFF; digit1 01001001; digit0 00000011.
   - value=16'h0000 -> digit0 00000011, others 8'hFF.
   - value=16'h0500 with dp[3]=1 -> digit3 SEG=8'b11111110.
5. Tear-free update:
   - Display 16'h2222; load 16'h1111 while index=2 -> digits 2,3 still show 2; digit 0 of the next frame shows 1.
   - load asserted on the wrap cycle -> the new value appears at digit 0 of the immediately following frame.
6. en/reset mid-frame:
   - en=0 at index 1 -> next cycle SEG=FF, AN=1111; frame_done still pulses on schedule. Re-enable -> the current index is shown one cycle later.
   - rst at index 2 -> next cycle outputs at reset values, index 0, pending discarded.
